// File: rtl/decoder_pkg.sv
// Shared types and the decode function for the streaming binary-to-one-hot
// decoder.
//   state_t   : skid buffer occupancy (EMPTY, ONE, TWO)
//   payload_t : {onehot, err} sized for the widest supported decoder
//   decode()  : code -> payload, flagging codes at or above n_out
package decoder_pkg;

  localparam int unsigned MAX_IN_W = 8;
  localparam int unsigned MAX_N    = 2 ** MAX_IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [MAX_N-1:0] onehot;
    logic             err;
  } payload_t;

  function automatic payload_t decode(input logic [MAX_IN_W-1:0] code,
                                      input int unsigned         n_out);
    payload_t p;
    p = '0;
    if (32'(code) < n_out) begin
      p.onehot[code] = 1'b1;
    end else begin
      p.err = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry skid buffer with valid/ready handshakes on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_valid    : upstream beat, accepted when in_ready is high
//   in_ready            : high unless both entries are occupied
//   out_data/out_valid  : head beat, driven straight from the main register
//   out_ready           : downstream accepts the head beat
// in_ready is decoded from the state register only, so it never depends
// combinationally on out_ready.
module skid_buf
  import decoder_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_xfer;
  logic         out_xfer;
  logic         load_main;
  logic         load_skid;
  logic         pop_skid;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          load_skid = 1'b1;
          state_nxt = TWO;
        end else if (!in_xfer && out_xfer) begin
          state_nxt = EMPTY;
        end else if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end
      end
      TWO: begin
        if (out_xfer) begin
          pop_skid  = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_q <= in_data;
      end else if (pop_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/decoder_bin2onehot.sv
// Streaming binary-to-one-hot decoder.
//   clk, rst    : clock, synchronous active-high reset
//   in_code     : binary code (IN_W bits, at most MAX_IN_W)
//   in_valid    : in_code valid this cycle
//   in_ready    : decoder can accept a code this cycle
//   out_onehot  : decoded vector, all-zero on error beats
//   out_err     : beat came from a code at or above N_OUT
//   out_valid   : output beat present
//   out_ready   : downstream accepts the beat
//   err_cnt     : invalid codes accepted since reset, saturating
module decoder_bin2onehot
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N_OUT-1:0] out_onehot,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_cnt
);

  payload_t            dec;
  logic [MAX_IN_W-1:0] code_ext;
  logic                spill;
  logic                in_err;
  logic [N_OUT:0]      in_pay;
  logic [N_OUT:0]      out_pay;

  // decode() never sets onehot bits at or above N_OUT; folding them into err
  // keeps every payload bit consumed without changing behaviour.
  always_comb begin
    code_ext = MAX_IN_W'(in_code);
    dec      = decode(code_ext, N_OUT);
    spill    = 1'b0;
    for (int unsigned i = N_OUT; i < MAX_N; i++) begin
      spill = spill | dec.onehot[i];
    end
    in_err = dec.err | spill;
    in_pay = {dec.onehot[N_OUT-1:0], in_err};
  end

  skid_buf #(
    .W(N_OUT + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_pay),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_pay),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_onehot = out_pay[N_OUT:1];
  assign out_err    = out_pay[0];

  // Counted at input acceptance, not when the beat leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (in_valid && in_ready && in_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decoder_bin2onehot.sv
module tb_decoder_bin2onehot;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: IN_W=2, N_OUT=4, CNT_W=8
  logic [1:0] a_code = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [3:0] a_oh;
  logic       a_err;
  logic       a_ovalid;
  logic       a_oready = 1'b1;
  logic [7:0] a_cnt;

  // DUT B: IN_W=2, N_OUT=3, CNT_W=2
  logic [1:0] b_code = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [2:0] b_oh;
  logic       b_err;
  logic       b_ovalid;
  logic       b_oready = 1'b1;
  logic [1:0] b_cnt;

  decoder_bin2onehot #(.IN_W(2), .N_OUT(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_code(a_code), .in_valid(a_valid), .in_ready(a_ready),
    .out_onehot(a_oh), .out_err(a_err), .out_valid(a_ovalid), .out_ready(a_oready),
    .err_cnt(a_cnt)
  );

  decoder_bin2onehot #(.IN_W(2), .N_OUT(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_code(b_code), .in_valid(b_valid), .in_ready(b_ready),
    .out_onehot(b_oh), .out_err(b_err), .out_valid(b_ovalid), .out_ready(b_oready),
    .err_cnt(b_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected payload of the beat currently offered, set by the stimulus.
  logic [3:0] a_exp_oh = '0;
  logic       a_exp_err = 1'b0;
  logic [2:0] b_exp_oh = '0;
  logic       b_exp_err = 1'b0;

  logic [4:0] qa[$];
  logic [3:0] qb[$];
  logic [7:0] a_cntm = '0;
  logic [1:0] b_cntm = '0;
  logic       a_held = 1'b0;
  logic       b_held = 1'b0;
  logic [4:0] a_held_beat = '0;
  logic [3:0] b_held_beat = '0;

  // Scoreboard monitor for A: pushes on acceptance, pops on output transfer.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst) begin
      qa.delete();
      a_cntm = '0;
      a_held = 1'b0;
    end else begin
      check("a_err_cnt", 32'(a_cnt), 32'(a_cntm));
      if (a_held) begin
        check("a_hold_valid", 32'(a_ovalid), 32'd1);
        check("a_hold_beat", 32'({a_oh, a_err}), 32'(a_held_beat));
      end
      if (a_ovalid && a_oready) begin
        if (qa.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_unexpected_beat: got %0h, required no beat", {a_oh, a_err});
        end else begin
          e = qa.pop_front();
          check("a_beat", 32'({a_oh, a_err}), 32'(e));
        end
      end
      a_held      = a_ovalid && !a_oready;
      a_held_beat = {a_oh, a_err};
      if (a_valid && a_ready) begin
        qa.push_back({a_exp_oh, a_exp_err});
        if (a_exp_err && a_cntm != 8'hff) a_cntm = a_cntm + 8'd1;
      end
    end
  end

  // Scoreboard monitor for B.
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst) begin
      qb.delete();
      b_cntm = '0;
      b_held = 1'b0;
    end else begin
      check("b_err_cnt", 32'(b_cnt), 32'(b_cntm));
      if (b_held) begin
        check("b_hold_valid", 32'(b_ovalid), 32'd1);
        check("b_hold_beat", 32'({b_oh, b_err}), 32'(b_held_beat));
      end
      if (b_ovalid && b_oready) begin
        if (qb.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_unexpected_beat: got %0h, required no beat", {b_oh, b_err});
        end else begin
          e = qb.pop_front();
          check("b_beat", 32'({b_oh, b_err}), 32'(e));
        end
      end
      b_held      = b_ovalid && !b_oready;
      b_held_beat = {b_oh, b_err};
      if (b_valid && b_ready) begin
        qb.push_back({b_exp_oh, b_exp_err});
        if (b_exp_err && b_cntm != 2'b11) b_cntm = b_cntm + 2'd1;
      end
    end
  end

  // Random out_ready toggling for B during the soak phase.
  logic rand_on = 1'b0;
  always @(posedge clk) begin
    if (rand_on) begin
      #1;
      b_oready = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_a(input logic [1:0] c, input logic [3:0] oh, input logic e);
    int unsigned n;
    a_valid = 1'b1; a_code = c; a_exp_oh = oh; a_exp_err = e;
    n = 0;
    @(negedge clk);
    while (a_ready !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL a_accept_timeout: in_ready %b, required 1", a_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] c, input logic [2:0] oh, input logic e);
    int unsigned n;
    b_valid = 1'b1; b_code = c; b_exp_oh = oh; b_exp_err = e;
    n = 0;
    @(negedge clk);
    while (b_ready !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL b_accept_timeout: in_ready %b, required 1", b_ready);
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [3:0] model_b(input logic [1:0] c);
    case (c)
      2'd0:    return 4'b001_0;
      2'd1:    return 4'b010_0;
      2'd2:    return 4'b100_0;
      default: return 4'b000_1;
    endcase
  endfunction

  // Hand-computed tables.
  logic [3:0] a_oh_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [1:0] sat_tab  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    logic [3:0]  pb;
    logic [1:0]  c;
    int unsigned n;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_a_ovalid", 32'(a_ovalid), 32'd0);
    check("rst_a_ready",  32'(a_ready),  32'd1);
    check("rst_a_oh",     32'(a_oh),     32'd0);
    check("rst_a_err",    32'(a_err),    32'd0);
    check("rst_a_cnt",    32'(a_cnt),    32'd0);
    check("rst_b_ovalid", 32'(b_ovalid), 32'd0);
    check("rst_b_cnt",    32'(b_cnt),    32'd0);

    // Stream 0..3 back to back, one-cycle latency each
    a_oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_a(2'(i), a_oh_tab[i], 1'b0);
      check("lat_valid", 32'(a_ovalid), 32'd1);
      check("lat_oh",    32'(a_oh),     32'(a_oh_tab[i]));
      check("lat_err",   32'(a_err),    32'd0);
      check("lat_ready", 32'(a_ready),  32'd1);
    end
    idle(3);
    check("stream_cnt", 32'(a_cnt), 32'd0);

    // Invalid code on N_OUT=3
    b_oready = 1'b1;
    send_b(2'd3, 3'b000, 1'b1);
    check("inv_oh",  32'(b_oh),  32'd0);
    check("inv_err", 32'(b_err), 32'd1);
    check("inv_cnt", 32'(b_cnt), 32'd1);
    idle(3);

    // Backpressure: two accepted, third waits
    a_oready = 1'b0;
    send_a(2'd0, 4'b0001, 1'b0);
    send_a(2'd1, 4'b0010, 1'b0);
    check("stall_ready_low", 32'(a_ready), 32'd0);
    a_valid = 1'b1; a_code = 2'd2; a_exp_oh = 4'b0100; a_exp_err = 1'b0;
    idle(2);
    check("stall_ready_still_low", 32'(a_ready), 32'd0);
    check("stall_head", 32'(a_oh), 32'h1);
    a_oready = 1'b1;
    @(posedge clk); #1;
    check("stall_ready_back", 32'(a_ready), 32'd1);
    send_a(2'd2, 4'b0100, 1'b0);
    idle(4);
    check("stall_drained", 32'(qa.size()), 32'd0);

    // Saturation with CNT_W=2
    pulse_rst();
    b_oready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_b(2'd3, 3'b000, 1'b1);
      check("sat_cnt", 32'(b_cnt), 32'(sat_tab[i]));
    end
    send_b(2'd1, 3'b010, 1'b0);
    check("sat_valid_code_cnt", 32'(b_cnt), 32'd3);
    idle(3);

    // Reset while holding two beats
    pulse_rst();
    b_oready = 1'b0;
    send_b(2'd3, 3'b000, 1'b1);
    send_b(2'd0, 3'b001, 1'b0);
    check("two_ready_low", 32'(b_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ovalid", 32'(b_ovalid), 32'd0);
    check("midrst_ready",  32'(b_ready),  32'd1);
    check("midrst_cnt",    32'(b_cnt),    32'd0);
    b_oready = 1'b1;
    idle(3);
    check("midrst_no_beat", 32'(b_ovalid), 32'd0);

    // Soak: 10k beats with random bubbles and random out_ready
    rand_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      c  = 2'($urandom_range(0, 3));
      pb = model_b(c);
      if ($urandom_range(0, 3) == 0) idle(1);
      send_b(c, pb[3:1], pb[0]);
    end
    rand_on = 1'b0;
    @(posedge clk); #2;
    b_oready = 1'b1;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("final_qa_empty", 32'(qa.size()), 32'd0);
    check("final_qb_empty", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decoder_bin2onehot.md
# decoder_bin2onehot

Streaming binary-to-one-hot decoder. It is the inverse of the team's one-hot-to-binary encoder and sits on the consumer side of any path that carries one-hot select vectors in encoded form. Each accepted code produces one output beat, registered, under valid/ready handshakes on both sides. A two-entry skid buffer sustains full throughput under backpressure. Codes outside the populated output range are flagged per beat and counted.

## Interface
- IN_W, 2: width of binary code input; must be at least 1.
- N_OUT, 4: number of one-hot output lines; legal range 2..2**IN_W; codes at or above N_OUT are invalid.
- CNT_W, 8: width of the saturating invalid-code counter.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_code  input  IN_W  binary code.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- out_onehot  output  N_OUT  decoded vector, bit in_code set.
- out_err  output  1  beat came from an invalid code; out_onehot is all-zero on such beats.
- out_valid  output  1  output beat is present.
- out_ready  input  1  downstream accepts the beat.
- err_cnt  output  CNT_W  count of invalid codes accepted since reset; saturates at all-ones.

## Operation
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Decode rule for an accepted code c:
  - c < N_OUT: out_onehot = 1 << c, out_err = 0.
  - c >= N_OUT: out_onehot = 0, out_err = 1, err_cnt increments unless it is already all-ones.
- Storage is a main register, which drives the outputs, plus a skid register. Both hold {onehot, err}.
- State machine: EMPTY, ONE (main valid), TWO (main and skid valid).
  - EMPTY: an input transfer loads main and moves to ONE.
  - ONE, input transfer without output transfer: loads skid, moves to TWO.
  - ONE, output transfer without input transfer: moves to EMPTY.
  - ONE, both transfers: main reloads from the input, stays ONE.
  - TWO: an output transfer moves skid into main and moves to ONE. in_ready is 0, so no input transfer can occur.
- Output order equals input order. No beat is dropped or duplicated.
- A held output beat is stable while out_valid && !out_ready. out_onehot and out_err do not change.
- err_cnt counts at input acceptance, not at output.

## Timing
- Reset values, taking effect at the first rising edge with rst=1:
  - state EMPTY.
  - out_valid=0, out_onehot=0, out_err=0, err_cnt=0.
  - in_ready=1.
  - While rst=1, input is ignored.
- Latency: a code accepted at edge N appears with out_valid=1 in the cycle after edge N, i.e. one cycle.
- in_ready is a registered output: in_ready = (state != TWO). It never depends combinationally on out_ready.
- Throughput is one beat per cycle with out_ready held at 1.
- Stalls:
  - At most two beats are buffered.
  - After out_ready drops, one further input is accepted, then in_ready falls.
  - in_ready returns to 1 the cycle after the first output transfer.
- Reset mid-operation discards both buffered beats. err_cnt clears. No output transfer is reported for the discarded beats.
- Saturation: when err_cnt is all-ones, further invalid codes leave it unchanged. Valid codes never change it.

## Structure
- Package decoder_pkg holds:
  - the state enum {EMPTY, ONE, TWO};
  - a payload struct {onehot, err};
  - a pure decode function taking code and N_OUT and returning the payload.
- Sub-module skid_buf holds the two-entry buffer, state machine and handshake, parameterised on payload width.
- The top level holds the decode function call, the err_cnt saturating counter and the port mapping.

## Test plan
- Reset, then stream codes 0,1,2,3 with out_ready=1.
  - Expect out_onehot 0001, 0010, 0100, 1000 on consecutive cycles, each one cycle after acceptance.
  - Expect out_err=0 throughout and err_cnt=0.
- N_OUT=3, IN_W=2, send code 3.
  - Expect out_onehot=000 and out_err=1.
  - Expect err_cnt=1 the cycle after acceptance.
- Hold out_ready=0 while streaming codes 0,1,2.
  - Expect 0 and 1 accepted and in_ready=0 after the second.
  - Raise out_ready: expect 0001, 0010, 0100 in order, no loss.
  - Expect in_ready=1 one cycle after the first output transfer.
- CNT_W=2: send five invalid codes.
  - Expect err_cnt to sequence 1,2,3,3,3.
- Assert rst for one cycle while in state TWO.
  - Expect out_valid=0, in_ready=1 and err_cnt=0 the next cycle.
  - Expect neither buffered beat to emerge.
- Random valid/ready toggling for 10k beats against a scoreboard model.
  - Expect order preserved, held beats stable, and err_cnt to match the model.
